// File: rtl/gray_pkg.sv
// Shared state encoding and default geometry for the RGB565-to-grayscale frame path.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } gray_state_e;

  localparam int GRAY_H_RES    = 320;
  localparam int GRAY_V_RES    = 240;
  localparam int GRAY_ADDR_W   = 17;
  localparam int GRAY_CONV_LAT = 2;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gray_frame_scheduler.sv
// Walks one frame from the RGB565 source through the external grayscale converter into
// the gray buffer; a single advance signal stalls the whole pipe under write backpressure.
module gray_frame_scheduler
  import gray_pkg::*;
#(
  parameter int  H_RES    = GRAY_H_RES,
  parameter int  V_RES    = GRAY_V_RES,
  parameter int  ADDR_W   = GRAY_ADDR_W,
  parameter int  CONV_LAT = GRAY_CONV_LAT,
  localparam int X_W      = clog2_min1(H_RES),
  localparam int Y_W      = clog2_min1(V_RES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [15:0]       src_rdata,
  output logic              conv_en,
  output logic [15:0]       conv_rgb,
  input  logic [7:0]        conv_gray,
  output logic              gray_we,
  input  logic              gray_ready,
  output logic [ADDR_W-1:0] gray_addr,
  output logic [7:0]        gray_data,
  output logic [X_W-1:0]    gray_x,
  output logic [Y_W-1:0]    gray_y,
  output logic              busy,
  output logic              frame_done
);

  localparam int NPIX  = H_RES * V_RES;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam logic [CNT_W-1:0] NPIX_C = CNT_W'(NPIX);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NPIX - 1);
  localparam logic [X_W-1:0]   X_LAST = X_W'(H_RES - 1);

  gray_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   src_base_q, src_base_d, dst_base_q, dst_base_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic                fresh_q, fresh_d, v_src_q, v_src_d;
  logic [15:0]         hold_q, hold_d;
  logic [CONV_LAT-1:0] v_q, v_d;
  logic                run, adv, wr_fire;

  assign run        = (state_q == RUN);
  assign gray_we    = v_q[CONV_LAT-1];
  assign adv        = run && !(gray_we && !gray_ready);
  assign wr_fire    = run && gray_we && gray_ready;
  assign src_rd_en  = adv && (rd_cnt_q < NPIX_C);
  assign src_addr   = src_base_q + ADDR_W'(rd_cnt_q);
  assign conv_en    = adv;
  assign conv_rgb   = fresh_q ? src_rdata : hold_q;
  assign gray_addr  = dst_base_q + ADDR_W'(wr_cnt_q);
  assign gray_data  = conv_gray;
  assign gray_x     = x_q;
  assign gray_y     = y_q;
  assign busy       = run;
  assign frame_done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (abort)                                state_d = IDLE;
        else if (wr_fire && (wr_cnt_q == LAST_C)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    src_base_d = src_base_q;
    dst_base_d = dst_base_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    fresh_d    = src_rd_en;
    hold_d     = hold_q;
    v_src_d    = v_src_q;
    v_d        = v_q;
    // A fetched pixel that cannot move on this cycle must outlive src_rdata.
    if (fresh_q && !adv) hold_d = src_rdata;
    if (adv) begin
      v_src_d = src_rd_en;
      v_d     = (v_q << 1) | CONV_LAT'(v_src_q);
    end
    if (src_rd_en) rd_cnt_d = rd_cnt_q + CNT_W'(1);
    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
    if (!run || abort) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
      x_d      = '0;
      y_d      = '0;
      fresh_d  = 1'b0;
      hold_d   = '0;
      v_src_d  = 1'b0;
      v_d      = '0;
    end
    if ((state_q == IDLE) && start) begin
      src_base_d = src_base;
      dst_base_d = dst_base;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_base_q <= '0;
      dst_base_q <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      fresh_q    <= 1'b0;
      hold_q     <= '0;
      v_src_q    <= 1'b0;
      v_q        <= '0;
    end else begin
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      fresh_q    <= fresh_d;
      hold_q     <= hold_d;
      v_src_q    <= v_src_d;
      v_q        <= v_d;
    end
  end

endmodule

// File: tb/tb_gray_frame_scheduler.sv
// Bench for gray_frame_scheduler: small 4x2 frame, behavioural source/converter/sink around the DUT.
`timescale 1ns/1ps
module tb_gray_frame_scheduler;

  localparam int H = 4, V = 2, AW = 17, LAT = 2, N = H * V;

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic [AW-1:0] src_base = '0, dst_base = '0, src_addr, gray_addr;
  logic          src_rd_en, conv_en, gray_we, busy, frame_done;
  logic          gray_ready = 1'b1;
  logic [15:0]   src_rdata = '0, conv_rgb;
  logic [7:0]    conv_gray, gray_data;
  logic [1:0]    gray_x;
  logic [0:0]    gray_y;

  gray_frame_scheduler #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .CONV_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rdata(src_rdata),
    .conv_en(conv_en), .conv_rgb(conv_rgb), .conv_gray(conv_gray),
    .gray_we(gray_we), .gray_ready(gray_ready), .gray_addr(gray_addr), .gray_data(gray_data),
    .gray_x(gray_x), .gray_y(gray_y), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gray_fn(input logic [15:0] p);
    int s;
    s = 77 * int'(p[15:11]) * 8 + 150 * int'(p[10:5]) * 4 + 29 * int'(p[4:0]) * 8;
    return 8'(s >> 8);
  endfunction

  // Source buffer: synchronous read, garbage on cycles without a read strobe.
  logic [15:0] mem [256];
  always @(posedge clk) src_rdata <= src_rd_en ? mem[src_addr[7:0]] : 16'($urandom);

  // Converter: fixed two-enable pipeline.
  logic [7:0] cs1, cs2;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs1 <= '0;
      cs2 <= '0;
    end else if (conv_en) begin
      cs1 <= gray_fn(conv_rgb);
      cs2 <= cs1;
    end
  end
  assign conv_gray = cs2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic [1:0]    x;
    logic [0:0]    y;
  } wr_t;

  wr_t  acc[$];
  int   done_q[$];
  wr_t  prev;
  int   checks = 0, errors = 0;
  int   base, hold_err, n_stall, last_we_rel, first_rd;
  int   restart_rel = -1, abort_rel = -1, rdy_mode = 0, stall_left = 0;
  logic stalled_prev, busy_at7;

  task automatic launch(input logic [AW-1:0] sb, input logic [AW-1:0] db);
    acc.delete();
    done_q.delete();
    hold_err = 0; n_stall = 0; last_we_rel = -1; first_rd = -1;
    stalled_prev = 1'b0; stall_left = 3; busy_at7 = 1'b1;
    @(negedge clk);
    src_base = sb; dst_base = db; start = 1'b1; gray_ready = 1'b1;
    base = cyc;
  endtask

  task automatic run_cycles(input int n);
    int rel;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rel   = cyc - base;
      start = (rel == restart_rel);
      abort = (rel == abort_rel);
      case (rdy_mode)
        0: gray_ready = 1'b1;
        1: begin
          gray_ready = 1'b1;
          if (gray_we && acc.size() == 2 && stall_left > 0) begin
            gray_ready = 1'b0;
            stall_left--;
          end
        end
        default: gray_ready = ($urandom_range(0, 2) != 0);
      endcase
      #1;
      if (stalled_prev && (!gray_we || gray_addr !== prev.a || gray_data !== prev.d ||
                           gray_x !== prev.x || gray_y !== prev.y)) hold_err++;
      if (gray_we && !gray_ready && conv_en) hold_err++;
      if (gray_we && !gray_ready) n_stall++;
      stalled_prev = gray_we && !gray_ready;
      prev = '{rel, gray_addr, gray_data, gray_x, gray_y};
      if (gray_we) last_we_rel = rel;
      if (gray_we && gray_ready) acc.push_back(prev);
      if (frame_done) done_q.push_back(rel);
      if (src_rd_en && first_rd < 0) first_rd = rel;
      if (rel == 7) busy_at7 = busy;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Reference frame: pixel i goes to dst+i at (i%H, i/H), first write at 2+LAT,
  // shifted by the stall length for writes at or after stall index s_at.
  function automatic int frame_errs(input logic [AW-1:0] sb, input logic [AW-1:0] db,
                                    input bit chk_cyc, input int s_at, input int s_len);
    int e = 0;
    if (acc.size() != N) return 1000 + acc.size();
    for (int i = 0; i < N; i++) begin
      logic [AW-1:0] sa, ea;
      int ec;
      sa = sb + AW'(i);
      ea = db + AW'(i);
      ec = 2 + LAT + i + ((i >= s_at) ? s_len : 0);
      if (acc[i].a !== ea || acc[i].d !== gray_fn(mem[sa[7:0]]) ||
          acc[i].x !== 2'(i % H) || acc[i].y !== 1'(i / H) ||
          (chk_cyc && acc[i].c != ec)) e++;
    end
    return e;
  endfunction

  function automatic int first_done();
    return (done_q.size() > 0) ? done_q[0] : -1;
  endfunction

  task automatic test_reset();
    logic [79:0] outs;
    @(negedge clk);
    outs = {src_rd_en, src_addr, conv_en, conv_rgb, gray_we, gray_addr, gray_data,
            gray_x, gray_y, busy, frame_done};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", outs);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_nominal();
    int fe;
    rdy_mode = 0;
    launch(17'h10, 17'h100);
    run_cycles(20);
    fe = frame_errs(17'h10, 17'h100, 1'b1, N, 0);
    checks++;
    if (fe != 0) begin errors++; $display("FAIL nominal_writes bad=%0d want 0", fe); end
    checks++;
    if (first_rd != 1) begin errors++; $display("FAIL nominal_first_read cycle=%0d want 1", first_rd); end
    checks++;
    if (done_q.size() != 1 || first_done() != 12) begin
      errors++;
      $display("FAIL nominal_done pulses=%0d at=%0d want 1 at 12", done_q.size(), first_done());
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL nominal_idle busy=%b want 0", busy); end
  endtask

  task automatic test_stall();
    int fe;
    rdy_mode = 1;
    launch(17'h10, 17'h100);
    run_cycles(25);
    fe = frame_errs(17'h10, 17'h100, 1'b1, 2, 3);
    checks++;
    if (fe != 0) begin errors++; $display("FAIL stall_writes bad=%0d want 0", fe); end
    checks++;
    if (first_done() != 15) begin errors++; $display("FAIL stall_done at=%0d want 15", first_done()); end
    checks++;
    if (hold_err != 0 || n_stall != 3) begin
      errors++;
      $display("FAIL stall_hold violations=%0d stalls=%0d want 0 and 3", hold_err, n_stall);
    end
  endtask

  task automatic test_back_to_back_start();
    int fe;
    rdy_mode = 0;
    restart_rel = 5;
    launch(17'h10, 17'h100);
    run_cycles(30);
    restart_rel = -1;
    fe = frame_errs(17'h10, 17'h100, 1'b1, N, 0);
    checks++;
    if (fe != 0) begin errors++; $display("FAIL restart_writes bad=%0d want 0", fe); end
    checks++;
    if (done_q.size() != 1 || first_done() != 12) begin
      errors++;
      $display("FAIL restart_done pulses=%0d at=%0d want 1 at 12", done_q.size(), first_done());
    end
  endtask

  task automatic test_abort();
    int fe;
    rdy_mode = 0;
    abort_rel = 6;
    launch(17'h10, 17'h100);
    run_cycles(20);
    abort_rel = -1;
    checks++;
    if (last_we_rel != 6) begin errors++; $display("FAIL abort_last_we cycle=%0d want 6", last_we_rel); end
    checks++;
    if (busy_at7 !== 1'b0) begin errors++; $display("FAIL abort_idle busy@7=%b want 0", busy_at7); end
    checks++;
    if (done_q.size() != 0) begin errors++; $display("FAIL abort_done pulses=%0d want 0", done_q.size()); end
    launch(17'h20, 17'h300);
    run_cycles(20);
    fe = frame_errs(17'h20, 17'h300, 1'b1, N, 0);
    checks++;
    if (fe != 0 || first_done() != 12) begin
      errors++;
      $display("FAIL abort_rerun bad=%0d done=%0d want 0 and 12", fe, first_done());
    end
  endtask

  task automatic test_reset_mid();
    int fe;
    logic [79:0] outs;
    rdy_mode = 0;
    launch(17'h10, 17'h100);
    run_cycles(6);
    reset = 1'b0;
    #1;
    outs = {src_rd_en, src_addr, conv_en, conv_rgb, gray_we, gray_addr, gray_data,
            gray_x, gray_y, busy, frame_done};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_mid_outputs got %h want 0", outs); end
    @(negedge clk);
    reset = 1'b1;
    launch(17'h40, 17'h180);
    run_cycles(20);
    fe = frame_errs(17'h40, 17'h180, 1'b1, N, 0);
    checks++;
    if (fe != 0 || first_done() != 12) begin
      errors++;
      $display("FAIL reset_mid_rerun bad=%0d done=%0d want 0 and 12", fe, first_done());
    end
  endtask

  task automatic test_wrap();
    int fe;
    logic [AW-1:0] sb, db, a3;
    rdy_mode = 0;
    sb = 17'h1FFFE;
    db = 17'h1FFFD;
    launch(sb, db);
    run_cycles(20);
    fe = frame_errs(sb, db, 1'b1, N, 0);
    checks++;
    if (fe != 0) begin errors++; $display("FAIL wrap_writes bad=%0d want 0", fe); end
    a3 = (acc.size() > 3) ? acc[3].a : '1;
    checks++;
    if (a3 !== '0) begin errors++; $display("FAIL wrap_addr4 got %h want 0", a3); end
  endtask

  task automatic test_random();
    int fe;
    logic [AW-1:0] sb, db;
    rdy_mode = 2;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      sb = AW'($urandom);
      db = AW'($urandom);
      launch(sb, db);
      run_cycles(80);
      fe = frame_errs(sb, db, 1'b0, N, 0);
      checks++;
      if (fe != 0 || hold_err != 0) begin
        errors++;
        $display("FAIL random%0d_writes bad=%0d holdviol=%0d want 0 and 0", it, fe, hold_err);
      end
      checks++;
      if (done_q.size() != 1 || first_done() != 12 + n_stall) begin
        errors++;
        $display("FAIL random%0d_done pulses=%0d at=%0d want 1 at %0d", it, done_q.size(),
                 first_done(), 12 + n_stall);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    test_reset();
    test_nominal();
    test_stall();
    test_back_to_back_start();
    test_abort();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
